// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Strobes are decoded from the registered state, so they clear as soon as rst asserts.
module cpu_stage_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             less,
    input  logic             mem_ready,
    output logic             fetch_req,
    output logic             ir_we,
    output logic             alu_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             fault
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT - 1);

    state_t        st, st_nxt;
    logic [WW-1:0] wait_cnt;
    logic          is_load, is_store, is_branch, is_legal;
    logic          br_bad, taken, in_wait, timeout, retire, done_nxt;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BR);
    assign is_legal  = (opcode == OP_R) || (opcode == OP_I) || is_load || is_store || is_branch ||
                       (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_LUI) ||
                       (opcode == OP_AUIPC);
    assign br_bad    = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:          taken = zero;
            3'b001:          taken = ~zero;
            3'b100, 3'b110:  taken = less;
            3'b101, 3'b111:  taken = ~less;
            default:         taken = 1'b0;
        endcase
    end

    // Wait counter only matters while a memory handshake is outstanding.
    assign in_wait  = (st == S_FETCH) || (st == S_MEM);
    assign timeout  = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TO_LAST);
    assign done_nxt = run;

    assign retire = ((st == S_EXEC) && is_branch && !br_bad) ||
                    ((st == S_MEM) && is_store && mem_ready) ||
                    (st == S_WB);

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:   if (run) st_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) st_nxt = S_DECODE;
                      else if (timeout) st_nxt = S_FAULT;
            S_DECODE: if (is_legal) st_nxt = S_EXEC;
                      else if (opcode == OP_ECALL) st_nxt = S_IDLE;
                      else st_nxt = S_FAULT;
            S_EXEC:   if (is_load || is_store) st_nxt = S_MEM;
                      else if (is_branch) st_nxt = br_bad ? S_FAULT : (done_nxt ? S_FETCH : S_IDLE);
                      else st_nxt = S_WB;
            S_MEM:    if (mem_ready) st_nxt = is_store ? (done_nxt ? S_FETCH : S_IDLE) : S_WB;
                      else if (timeout) st_nxt = S_FAULT;
            S_WB:     st_nxt = done_nxt ? S_FETCH : S_IDLE;
            S_FAULT:  st_nxt = S_FAULT;
            default:  st_nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            st        <= st_nxt;
            wait_cnt  <= (in_wait && !mem_ready) ? wait_cnt + 1'b1 : '0;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign fetch_req = (st == S_FETCH);
    assign ir_we     = (st == S_FETCH) && mem_ready;
    assign alu_en    = (st == S_EXEC);
    assign mem_rd    = (st == S_MEM) && is_load;
    assign mem_wr    = (st == S_MEM) && is_store;
    assign reg_we    = (st == S_WB);
    assign pc_we     = retire;

    always_comb begin
        pc_sel = 2'b00;
        if (st == S_EXEC && is_branch && taken) pc_sel = 2'b01;
        else if (st == S_WB && opcode == OP_JAL) pc_sel = 2'b01;
        else if (st == S_WB && opcode == OP_JALR) pc_sel = 2'b10;
    end

    assign state = st;
    assign fault = (st == S_FAULT);
endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Directed bench for cpu_stage_ctrl with a short timeout and a 2-bit counter to reach the wrap quickly.
module tb_cpu_stage_ctrl;
    logic       clk = 1'b0;
    logic       rst, run, zero, less, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       fetch_req, ir_we, alu_en, mem_rd, mem_wr, reg_we, pc_we, fault;
    logic [1:0] pc_sel;
    logic [2:0] state;
    logic [1:0] instr_cnt;
    logic [8:0] strb;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_cnt = 0;

    cpu_stage_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3), .zero(zero),
        .less(less), .mem_ready(mem_ready), .fetch_req(fetch_req), .ir_we(ir_we),
        .alu_en(alu_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .state(state), .instr_cnt(instr_cnt), .fault(fault)
    );

    always #5 clk = ~clk;

    // {fetch_req, ir_we, alu_en, mem_rd, mem_wr, reg_we, pc_we, pc_sel}
    assign strb = {fetch_req, ir_we, alu_en, mem_rd, mem_wr, reg_we, pc_we, pc_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st, input logic [8:0] s);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strb"}, 32'(strb), 32'(s));
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(instr_cnt), 32'(exp_cnt % 4));
    endtask

    task automatic set_op(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Runs one ALU-class (FETCH,DECODE,EXEC,WB) instruction with zero-wait memory.
    task automatic run_wb(input string tag, input logic [6:0] op, input logic [1:0] sel);
        set_op(op, 3'b000); mem_ready = 1'b1;
        expect_st({tag, ".f"}, 3'd1, 9'b110000000); cyc();
        expect_st({tag, ".d"}, 3'd2, 9'b000000000); cyc();
        expect_st({tag, ".e"}, 3'd3, 9'b001000000); cyc();
        expect_st({tag, ".wb"}, 3'd5, {7'b0000011, sel}); cyc();
        exp_cnt++;
        chk_cnt({tag, ".cnt"});
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic z, input logic l,
                          input logic [1:0] sel);
        set_op(7'b1100011, f3); zero = z; less = l; mem_ready = 1'b1;
        expect_st({tag, ".f"}, 3'd1, 9'b110000000); cyc();
        expect_st({tag, ".d"}, 3'd2, 9'b000000000); cyc();
        expect_st({tag, ".e"}, 3'd3, {7'b0010001, sel}); cyc();
        exp_cnt++;
        chk_cnt({tag, ".cnt"});
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; zero = 1'b0; less = 1'b0; mem_ready = 1'b0;
        opcode = 7'b0; funct3 = 3'b0;
        #1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.strb", 32'(strb), 32'd0);
        chk("rst.cnt", 32'(instr_cnt), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // ADDI through WB
        run = 1'b1; set_op(7'b0010011, 3'b000); mem_ready = 1'b1;
        expect_st("idle", 3'd0, 9'b000000000); cyc();
        run_wb("addi", 7'b0010011, 2'b00);

        // LW with three wait cycles in MEM
        set_op(7'b0000011, 3'b010);
        expect_st("lw.f", 3'd1, 9'b110000000); cyc();
        expect_st("lw.d", 3'd2, 9'b000000000); cyc();
        mem_ready = 1'b0;
        expect_st("lw.e", 3'd3, 9'b001000000); cyc();
        for (int i = 0; i < 3; i++) begin
            expect_st("lw.wait", 3'd4, 9'b000100000); cyc();
        end
        mem_ready = 1'b1;
        expect_st("lw.rdy", 3'd4, 9'b000100000); cyc();
        expect_st("lw.wb", 3'd5, 9'b000001100); cyc();
        exp_cnt++;
        chk_cnt("lw.cnt");

        // Branches; the fourth retirement wraps the 2-bit counter
        run_br("beq_t", 3'b000, 1'b1, 1'b0, 2'b01);
        run_br("bne_nt", 3'b001, 1'b1, 1'b0, 2'b00);
        chk("wrap", 32'(instr_cnt), 32'd0);
        run_br("bgeu_t", 3'b111, 1'b0, 1'b0, 2'b01);
        run_br("blt_t", 3'b100, 1'b0, 1'b1, 2'b01);
        run_wb("jal", 7'b1101111, 2'b01);
        run_wb("jalr", 7'b1100111, 2'b10);
        run_wb("lui", 7'b0110111, 2'b00);

        // SW with run dropped during EXEC completes, then parks in IDLE
        set_op(7'b0100011, 3'b010);
        expect_st("sw.f", 3'd1, 9'b110000000); cyc();
        expect_st("sw.d", 3'd2, 9'b000000000); cyc();
        run = 1'b0;
        expect_st("sw.e", 3'd3, 9'b001000000); cyc();
        expect_st("sw.mem", 3'd4, 9'b000010100); cyc();
        exp_cnt++;
        expect_st("sw.idle", 3'd0, 9'b000000000);
        chk_cnt("sw.cnt");
        cyc();
        expect_st("sw.stay", 3'd0, 9'b000000000);

        // ECALL returns to IDLE without retiring
        run = 1'b1; set_op(7'b1110011, 3'b000);
        cyc();
        expect_st("ecall.f", 3'd1, 9'b110000000); cyc();
        run = 1'b0;
        expect_st("ecall.d", 3'd2, 9'b000000000); cyc();
        expect_st("ecall.idle", 3'd0, 9'b000000000);
        chk_cnt("ecall.cnt");

        // Illegal opcode faults from DECODE
        run = 1'b1; set_op(7'b0000000, 3'b000);
        cyc();
        expect_st("ill.f", 3'd1, 9'b110000000); cyc();
        expect_st("ill.d", 3'd2, 9'b000000000); cyc();
        expect_st("ill.fault", 3'd6, 9'b000000000);
        chk("ill.faultflag", 32'(fault), 32'd1);
        chk_cnt("ill.cnt");

        // Reset clears FAULT asynchronously
        rst = 1'b1;
        #2;
        chk("rst_async.state", 32'(state), 32'd0);
        chk("rst_async.fault", 32'(fault), 32'd0);
        chk("rst_async.cnt", 32'(instr_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        exp_cnt = 0;

        // Fetch timeout after four unacknowledged cycles
        run = 1'b1; mem_ready = 1'b0; set_op(7'b0010011, 3'b000);
        cyc();
        for (int i = 0; i < 4; i++) begin
            expect_st("to.wait", 3'd1, 9'b100000000); cyc();
        end
        expect_st("to.fault", 3'd6, 9'b000000000);
        chk("to.faultflag", 32'(fault), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run = ~run; mem_ready = ~mem_ready;
            cyc();
            chk("to.sticky", 32'(state), 32'd6);
        end
        rst = 1'b1;
        #2;
        chk("to.rst.state", 32'(state), 32'd0);
        chk("to.rst.fault", 32'(fault), 32'd0);
        cyc();
        rst = 1'b0;

        // Strobes drop at once when rst asserts mid-fetch
        run = 1'b1; mem_ready = 1'b0;
        cyc();
        expect_st("midrst.f", 3'd1, 9'b100000000);
        rst = 1'b1;
        #1;
        chk("midrst.strb", 32'(strb), 32'd0);
        cyc();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
